jb_predict_resolve_unit: RTL and testbench

- Next-generation jump/branch control unit for the rv32i pipeline.
- Predicts conditional-branch direction in ID with a parametrised table of saturating counters (BHT). Resolves branches, JAL and JALR in EX with an internal comparator.
- Drives the PC mux select and flush, and trains the BHT.
- Keeps saturating branch/mispredict performance counters.

---
 rtl/jb_predict_resolve_unit.sv | 133 +++++++++++++
 tb/tb_jb_predict_resolve_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jb_predict_resolve_unit.sv
// Jump/branch predict-and-resolve unit for the rv32i pipeline.
// The ID stage reads a table of saturating counters (BHT) to predict branch direction.
// The EX stage resolves branches, JAL and JALR, selects the PC mux and trains the BHT.

package jb_predict_resolve_pkg;
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_t;
endpackage

module jb_predict_resolve_unit
    import jb_predict_resolve_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CTR_W    = 2,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              id_valid,
    input  logic              id_is_branch,
    input  logic [31:0]       id_pc,
    output logic              id_pred_taken,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic [1:0]        ex_jb_sel,
    input  branch_funct3_t    ex_cmpop,
    input  logic [31:0]       ex_rs1_out,
    input  logic [31:0]       ex_rs2_out,
    input  logic              ex_pred_taken,
    output logic [1:0]        pcmux_sel,
    output logic              flush,
    output logic [PERF_W-1:0] branch_count,
    output logic [PERF_W-1:0] mispredict_count
);

    localparam int                ENTRIES  = 1 << IDX_BITS;
    localparam logic [CTR_W-1:0]  CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [ENTRIES-1:0][CTR_W-1:0] bht_q, bht_d;
    logic [PERF_W-1:0]             branch_count_q, branch_count_d;
    logic [PERF_W-1:0]             mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0] id_idx, ex_idx;
    logic                br_taken, ex_act, ex_is_cond, ex_is_jump, mispredict;

    // Only the index bits of the PCs matter here; everything else is intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{id_pc[31:IDX_BITS+2], id_pc[1:0], ex_pc[31:IDX_BITS+2], ex_pc[1:0]};

    assign id_idx = id_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];

    // Same-cycle table read; a write to the same entry this cycle shows up next cycle.
    assign id_pred_taken = id_valid & id_is_branch & bht_q[id_idx][CTR_W-1];

    // Branch comparator; unknown funct3 encodings resolve not-taken.
    always_comb begin
        br_taken = 1'b0;
        case (ex_cmpop)
            F3_BEQ:  br_taken = (ex_rs1_out == ex_rs2_out);
            F3_BNE:  br_taken = (ex_rs1_out != ex_rs2_out);
            F3_BLT:  br_taken = ($signed(ex_rs1_out) <  $signed(ex_rs2_out));
            F3_BGE:  br_taken = ($signed(ex_rs1_out) >= $signed(ex_rs2_out));
            F3_BLTU: br_taken = (ex_rs1_out <  ex_rs2_out);
            F3_BGEU: br_taken = (ex_rs1_out >= ex_rs2_out);
            default: br_taken = 1'b0;
        endcase
    end

    // Redirect selection: EX redirect beats ID prediction, which beats sequential fetch.
    always_comb begin
        ex_act     = ex_valid & ~stall;
        ex_is_cond = (ex_jb_sel == 2'b00);
        ex_is_jump = (ex_jb_sel == 2'b01) | (ex_jb_sel == 2'b10);
        mispredict = ex_act & ex_is_cond & (br_taken != ex_pred_taken);
        pcmux_sel  = 2'b00;
        flush      = 1'b0;
        if (ex_act && ex_is_jump) begin
            pcmux_sel = 2'b10;
            flush     = 1'b1;
        end else if (mispredict) begin
            pcmux_sel = br_taken ? 2'b10 : 2'b11;
            flush     = 1'b1;
        end else if (id_pred_taken && !stall) begin
            pcmux_sel = 2'b01;
        end
    end

    // BHT training and saturating perf counters for resolved conditional branches.
    always_comb begin
        bht_d              = bht_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (ex_act && ex_is_cond) begin
            if (br_taken) begin
                if (bht_q[ex_idx] != CTR_MAX) bht_d[ex_idx] = bht_q[ex_idx] + CTR_ONE;
            end else begin
                if (bht_q[ex_idx] != '0) bht_d[ex_idx] = bht_q[ex_idx] - CTR_ONE;
            end
            if (branch_count_q != PERF_MAX) branch_count_d = branch_count_q + PERF_ONE;
            if (mispredict && mispredict_count_q != PERF_MAX)
                mispredict_count_d = mispredict_count_q + PERF_ONE;
        end
    end

    // State registers; reset returns every entry to weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bht_q              <= {ENTRIES{CTR_INIT}};
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_jb_predict_resolve_unit.sv
// Self-checking bench for jb_predict_resolve_unit (PERF_W=4 build to reach counter saturation).
module tb_jb_predict_resolve_unit;
    import jb_predict_resolve_pkg::*;

    logic        clk, rst, stall;
    logic        id_valid, id_is_branch, id_pred_taken;
    logic [31:0] id_pc, ex_pc, ex_rs1_out, ex_rs2_out;
    logic        ex_valid, ex_pred_taken, flush;
    logic [1:0]  ex_jb_sel, pcmux_sel;
    branch_funct3_t ex_cmpop;
    logic [3:0]  branch_count, mispredict_count;

    jb_predict_resolve_unit #(.IDX_BITS(6), .CTR_W(2), .PERF_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .id_valid(id_valid), .id_is_branch(id_is_branch), .id_pc(id_pc),
        .id_pred_taken(id_pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_jb_sel(ex_jb_sel), .ex_cmpop(ex_cmpop),
        .ex_rs1_out(ex_rs1_out), .ex_rs2_out(ex_rs2_out), .ex_pred_taken(ex_pred_taken),
        .pcmux_sel(pcmux_sel), .flush(flush),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        id_v;
        logic [31:0] id_pc;
        logic        ex_v;
        logic [31:0] ex_pc;
        logic [1:0]  sel;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        pt;
        logic        e_pred;
        logic [1:0]  e_mux;
        logic        e_flush;
        logic [3:0]  e_bc, e_mc;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[26];
    vec_t sb_q[$];

    function automatic vec_t mk(logic st, logic idv, logic [31:0] ipc, logic exv, logic [31:0] epc,
                                logic [1:0] sel, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                logic pt, logic ep, logic [1:0] em, logic ef, logic [3:0] bc, logic [3:0] mc);
        vec_t v;
        v.stall = st; v.id_v = idv; v.id_pc = ipc; v.ex_v = exv; v.ex_pc = epc;
        v.sel = sel; v.op = op; v.a = a; v.b = b; v.pt = pt;
        v.e_pred = ep; v.e_mux = em; v.e_flush = ef; v.e_bc = bc; v.e_mc = mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; id_valid = 1'b0; id_is_branch = 1'b0; id_pc = 32'h0;
        ex_valid = 1'b0; ex_pc = 32'h0; ex_jb_sel = 2'b11; ex_cmpop = F3_BEQ;
        ex_rs1_out = 32'h0; ex_rs2_out = 32'h0; ex_pred_taken = 1'b0;
    endtask

    // Drive one vector at negedge, queue its expectations, check comb outputs then post-edge counters.
    task automatic apply(input vec_t v, input int n);
        vec_t e;
        @(negedge clk);
        stall = v.stall; id_valid = v.id_v; id_is_branch = v.id_v; id_pc = v.id_pc;
        ex_valid = v.ex_v; ex_pc = v.ex_pc; ex_jb_sel = v.sel; ex_cmpop = branch_funct3_t'(v.op);
        ex_rs1_out = v.a; ex_rs2_out = v.b; ex_pred_taken = v.pt;
        sb_q.push_back(v);
        #2;
        e = sb_q.pop_front();
        chk($sformatf("v%0d pred", n), {31'b0, id_pred_taken}, {31'b0, e.e_pred});
        chk($sformatf("v%0d pcmux", n), {30'b0, pcmux_sel}, {30'b0, e.e_mux});
        chk($sformatf("v%0d flush", n), {31'b0, flush}, {31'b0, e.e_flush});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d branch_count", n), {28'b0, branch_count}, {28'b0, e.e_bc});
        chk($sformatf("v%0d mispredict_count", n), {28'b0, mispredict_count}, {28'b0, e.e_mc});
    endtask

    initial begin
        //            st idv id_pc    exv ex_pc    sel    op      a             b   pt  pred mux  fl bc mc
        vecs[0]  = mk(0, 1, 32'h100, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  0, 2'b00, 0, 0, 0);
        vecs[1]  = mk(0, 1, 32'h100, 1, 32'h100, 2'b00, 3'b000, 5,            5,  0,  0, 2'b10, 1, 1, 1);
        vecs[2]  = mk(0, 1, 32'h100, 1, 32'h100, 2'b00, 3'b000, 5,            5,  0,  1, 2'b10, 1, 2, 2);
        vecs[3]  = mk(0, 1, 32'h100, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  1, 2'b01, 0, 2, 2);
        vecs[4]  = mk(0, 1, 32'h100, 1, 32'h100, 2'b00, 3'b101, 32'hFFFFFFFF, 1,  1,  1, 2'b11, 1, 3, 3);
        vecs[5]  = mk(0, 1, 32'h100, 1, 32'h100, 2'b00, 3'b111, 32'hFFFFFFFF, 1,  1,  1, 2'b01, 0, 4, 3);
        vecs[6]  = mk(0, 1, 32'h100, 1, 32'h204, 2'b10, 3'b000, 5,            5,  0,  1, 2'b10, 1, 4, 3);
        vecs[7]  = mk(0, 1, 32'h204, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  0, 2'b00, 0, 4, 3);
        vecs[8]  = mk(0, 0, 32'h204, 1, 32'h204, 2'b01, 3'b000, 5,            5,  0,  0, 2'b10, 1, 4, 3);
        vecs[9]  = mk(0, 1, 32'h204, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  0, 2'b00, 0, 4, 3);
        vecs[10] = mk(0, 0, 32'h000, 1, 32'h204, 2'b11, 3'b000, 5,            5,  0,  0, 2'b00, 0, 4, 3);
        vecs[11] = mk(0, 1, 32'h204, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  0, 2'b00, 0, 4, 3);
        vecs[12] = mk(1, 1, 32'h204, 1, 32'h204, 2'b00, 3'b000, 5,            5,  0,  0, 2'b00, 0, 4, 3);
        vecs[13] = mk(0, 1, 32'h204, 1, 32'h204, 2'b00, 3'b000, 5,            5,  0,  0, 2'b10, 1, 5, 4);
        vecs[14] = mk(0, 1, 32'h204, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  1, 2'b01, 0, 5, 4);
        vecs[15] = mk(1, 1, 32'h100, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  1, 2'b00, 0, 5, 4);
        vecs[16] = mk(0, 0, 32'h000, 1, 32'h300, 2'b00, 3'b001, 5,            5,  1,  0, 2'b11, 1, 6, 5);
        vecs[17] = mk(0, 1, 32'h100, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  1, 2'b01, 0, 6, 5);
        vecs[18] = mk(0, 0, 32'h000, 1, 32'h008, 2'b00, 3'b100, 32'hFFFFFFFF, 1,  0,  0, 2'b10, 1, 7, 6);
        vecs[19] = mk(0, 0, 32'h000, 1, 32'h008, 2'b00, 3'b110, 32'hFFFFFFFF, 1,  0,  0, 2'b00, 0, 8, 6);
        vecs[20] = mk(0, 1, 32'h008, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  0, 2'b00, 0, 8, 6);
        vecs[21] = mk(0, 0, 32'h000, 1, 32'h00C, 2'b00, 3'b010, 5,            5,  1,  0, 2'b11, 1, 9, 7);
        vecs[22] = mk(0, 0, 32'h000, 0, 32'h00C, 2'b00, 3'b010, 5,            5,  1,  0, 2'b00, 0, 9, 7);
        vecs[23] = mk(0, 0, 32'h000, 1, 32'h00C, 2'b00, 3'b010, 5,            5,  0,  0, 2'b00, 0, 10, 7);
        vecs[24] = mk(0, 0, 32'h000, 1, 32'h00C, 2'b00, 3'b000, 5,            5,  0,  0, 2'b10, 1, 11, 8);
        vecs[25] = mk(0, 1, 32'h00C, 0, 32'h000, 2'b11, 3'b000, 0,            0,  0,  0, 2'b00, 0, 11, 8);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset branch_count", {28'b0, branch_count}, 32'h0);
        chk("reset mispredict_count", {28'b0, mispredict_count}, 32'h0);
        chk("reset pcmux", {30'b0, pcmux_sel}, 32'h0);
        chk("reset flush", {31'b0, flush}, 32'h0);

        for (int i = 0; i < 26; i++) apply(vecs[i], i);

        // Drive repeated mispredicts on index 4 until both counters pin at all-ones.
        for (int k = 0; k < 12; k++) begin
            int bc, mc;
            bc = (12 + k > 15) ? 15 : 12 + k;
            mc = (9 + k > 15) ? 15 : 9 + k;
            apply(mk(0, 0, 32'h0, 1, 32'h010, 2'b00, 3'b000, 5, 5, 0, 0, 2'b10, 1,
                     4'(bc), 4'(mc)), 100 + k);
        end

        // Asynchronous reset mid-cycle: state must clear before any clock edge.
        @(negedge clk);
        idle_inputs();
        id_valid = 1'b1; id_is_branch = 1'b1; id_pc = 32'h010;
        #1;
        chk("pre-reset pred idx4", {31'b0, id_pred_taken}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async reset pred idx4", {31'b0, id_pred_taken}, 32'h0);
        chk("async reset branch_count", {28'b0, branch_count}, 32'h0);
        chk("async reset mispredict_count", {28'b0, mispredict_count}, 32'h0);
        id_pc = 32'h100;
        #1;
        chk("async reset pred idx0", {31'b0, id_pred_taken}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
